// File: rtl/eth_phy_10g_rx_ber_mon_if.sv
// Signal bundle between the block aligner side and the BER monitor.
// The count port pair exists only when BER_MON_CNT_EN is defined.
interface eth_phy_10g_rx_ber_mon_if #(
    parameter int HDR_WIDTH = 2
);
    logic [HDR_WIDTH-1:0] i_serdes_rx_hdr;
    logic                 i_rx_block_lock;
    logic                 o_rx_high_ber;
    logic                 o_rx_bad_hdr;
`ifdef BER_MON_CNT_EN
    logic [5:0]           o_ber_count;
    logic                 i_ber_count_clr;
`endif

    modport master (
`ifdef BER_MON_CNT_EN
        output i_ber_count_clr,
        input  o_ber_count,
`endif
        output i_serdes_rx_hdr,
        output i_rx_block_lock,
        input  o_rx_high_ber,
        input  o_rx_bad_hdr
    );

    modport slave (
`ifdef BER_MON_CNT_EN
        input  i_ber_count_clr,
        output o_ber_count,
`endif
        input  i_serdes_rx_hdr,
        input  i_rx_block_lock,
        output o_rx_high_ber,
        output o_rx_bad_hdr
    );
endinterface

// File: rtl/eth_phy_10g_rx_ber_mon.sv
// Cl.49-style receive BER monitor: counts invalid sync headers per window, flags high BER.
// Optional BER_MON_CNT_EN adds a saturating 6-bit invalid-header counter with clear.
module eth_phy_10g_rx_ber_mon #(
    parameter int HDR_WIDTH     = 2,
    parameter int COUNT_125US   = 19531,
    parameter int BER_THRESHOLD = 16
) (
    input  logic                      clk,
    input  logic                      i_rst,
    eth_phy_10g_rx_ber_mon_if.slave   bus
);
    localparam int TW = $clog2(COUNT_125US);
    localparam int EW = $clog2(BER_THRESHOLD + 1);

    typedef enum logic [1:0] {INIT, COUNT, HI_BER} state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [EW-1:0]  err_q,   err_d;
    logic           high_ber_q, high_ber_d;
    logic           bad_hdr_q;

    logic           lock, hdr_bad, timer_last, err_at_thr, err_sat;
    logic [TW-1:0]  timer_inc;

    assign lock       = bus.i_rx_block_lock;
    // 00 and 11 are the two invalid headers: both bits equal
    assign hdr_bad    = ~^bus.i_serdes_rx_hdr[1:0];
    assign timer_last = (timer_q == TW'(COUNT_125US - 1));
    assign timer_inc  = timer_last ? '0 : timer_q + 1'b1;
    assign err_at_thr = (err_q == EW'(BER_THRESHOLD - 1));
    assign err_sat    = (err_q == EW'(BER_THRESHOLD));

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        err_d      = err_q;
        high_ber_d = high_ber_q;
        if (!lock) begin
            state_d    = INIT;
            timer_d    = '0;
            err_d      = '0;
            high_ber_d = 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    // header in the lock-acquire cycle is not counted
                    state_d    = COUNT;
                    timer_d    = '0;
                    err_d      = '0;
                    high_ber_d = 1'b0;
                end
                COUNT: begin
                    timer_d = timer_inc;
                    if (hdr_bad && !err_sat)
                        err_d = err_q + 1'b1;
                    // threshold wins over window expiry in the same cycle
                    if (hdr_bad && err_at_thr) begin
                        state_d    = HI_BER;
                        high_ber_d = 1'b1;
                    end else if (timer_last) begin
                        err_d      = '0;
                        high_ber_d = 1'b0;
                    end
                end
                HI_BER: begin
                    high_ber_d = 1'b1;
                    timer_d    = timer_inc;
                    if (timer_last) begin
                        state_d = COUNT;
                        err_d   = '0;
                    end
                end
                default: begin
                    state_d    = INIT;
                    timer_d    = '0;
                    err_d      = '0;
                    high_ber_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q    <= INIT;
            timer_q    <= '0;
            err_q      <= '0;
            high_ber_q <= 1'b0;
            bad_hdr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            err_q      <= err_d;
            high_ber_q <= high_ber_d;
            bad_hdr_q  <= lock && hdr_bad && (state_q != INIT);
        end
    end

    assign bus.o_rx_high_ber = high_ber_q;
    assign bus.o_rx_bad_hdr  = bad_hdr_q;

`ifdef BER_MON_CNT_EN
    logic [5:0] ber_cnt_q;
    logic       cnt_hit;

    // lock loss deliberately leaves the running count untouched
    assign cnt_hit = lock && hdr_bad;

    always_ff @(posedge clk) begin
        if (i_rst)
            ber_cnt_q <= '0;
        else if (bus.i_ber_count_clr)
            ber_cnt_q <= {5'd0, cnt_hit};
        else if (cnt_hit && ber_cnt_q != 6'd63)
            ber_cnt_q <= ber_cnt_q + 6'd1;
    end

    assign bus.o_ber_count = ber_cnt_q;
`endif
endmodule
